// File: rtl/health_bar_ctrl_pkg.sv
// Shared game types and defaults for the health bar controller and its neighbours.
// Both FSM encodings live here so the game-logic FSM can decode them too.
package game_pkg;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } player_state_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIGHT    = 2'd1,
        DEFEATED = 2'd2
    } boss_state_t;

    localparam int PLAYER_MAX_DEF = 3;
    localparam int BOSS_MAX_DEF   = 6;

    // Width of a counter that must hold 0..max inclusive.
    function automatic int count_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/health_bar_ctrl_if.sv
// Event pulses from the game-logic FSM in, health status and LED bar out.
// The master side is the game logic; the slave side is health_bar_ctrl.
interface health_bar_ctrl_if
    import game_pkg::*;
#(
    parameter int PLAYER_MAX = PLAYER_MAX_DEF,
    parameter int BOSS_MAX   = BOSS_MAX_DEF,
    parameter int BAR_W      = 10
);
    localparam int PW = count_w(PLAYER_MAX);
    localparam int BW = count_w(BOSS_MAX);

    logic             tick;
    logic             new_game;
    logic             player_hit;
    logic             player_heal;
    logic             boss_active;
    logic             boss_hit;
    logic [PW-1:0]    player_health;
    logic [BW-1:0]    boss_health;
    logic             player_dead;
    logic             boss_dead;
    logic [BAR_W-1:0] out;

    modport master (
        output tick, new_game, player_hit, player_heal, boss_active, boss_hit,
        input  player_health, boss_health, player_dead, boss_dead, out
    );

    modport slave (
        input  tick, new_game, player_hit, player_heal, boss_active, boss_hit,
        output player_health, boss_health, player_dead, boss_dead, out
    );

endinterface

// File: rtl/health_bar_ctrl_therm_bar.sv
// Thermometer encoder: bit i lights when value > i; REVERSE mirrors the bar so it
// fills from the MSB downward.
module therm_bar #(
    parameter int N       = 3,
    parameter int REVERSE = 0,
    parameter int W       = $clog2(N + 1)
) (
    input  logic [W-1:0] value,
    output logic [N-1:0] bar
);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            if (REVERSE != 0) begin : g_rev
                assign bar[N-1-gi] = (value > W'(gi));
            end else begin : g_fwd
                assign bar[gi] = (value > W'(gi));
            end
        end
    endgenerate

endmodule

// File: rtl/health_bar_ctrl.sv
// Player/boss health tracker with i-frame blink and a registered LED bar:
// player thermometer in the low bits, boss bar right-aligned in the high bits.
module health_bar_ctrl
    import game_pkg::*;
#(
    parameter int PLAYER_MAX   = PLAYER_MAX_DEF,
    parameter int BOSS_MAX     = BOSS_MAX_DEF,
    parameter int BAR_W        = 10,
    parameter int IFRAME_TICKS = 4,
    parameter int BLINK_TICKS  = 1
) (
    input  logic             clk,
    input  logic             resetn,
    health_bar_ctrl_if.slave bus
);

    localparam int PW = count_w(PLAYER_MAX);
    localparam int BW = count_w(BOSS_MAX);
    localparam int IW = count_w(IFRAME_TICKS);
    localparam int KW = count_w(BLINK_TICKS);

    localparam logic [PW-1:0] P_MAX  = PW'(PLAYER_MAX);
    localparam logic [BW-1:0] B_MAX  = BW'(BOSS_MAX);
    localparam logic [IW-1:0] I_LOAD = IW'(IFRAME_TICKS);
    localparam logic [KW-1:0] K_LOAD = KW'(BLINK_TICKS);

    generate
        if (BAR_W < PLAYER_MAX + BOSS_MAX || PLAYER_MAX == 0 || BOSS_MAX == 0 ||
            BAR_W == 0 || IFRAME_TICKS == 0 || BLINK_TICKS == 0) begin : g_bad_params
            $error("health_bar_ctrl: illegal parameter set");
        end
    endgenerate

    player_state_t    p_state_reg,  p_state_next;
    logic [PW-1:0]    p_health_reg, p_health_next;
    logic [IW-1:0]    iframe_reg,   iframe_next;
    logic [KW-1:0]    blink_reg,    blink_next;
    logic             phase_reg,    phase_next;

    boss_state_t      b_state_reg,  b_state_next;
    logic [BW-1:0]    b_health_reg, b_health_next;
    logic             b_dead_reg,   b_dead_next;

    logic [BAR_W-1:0] out_reg,      out_next;

    logic [PLAYER_MAX-1:0] player_bar;
    logic [BOSS_MAX-1:0]   boss_bar;
    logic [BW-1:0]         boss_level;
    logic                  player_blank;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p_state_reg  <= ALIVE;
            p_health_reg <= P_MAX;
            iframe_reg   <= '0;
            blink_reg    <= '0;
            phase_reg    <= 1'b0;
            b_state_reg  <= IDLE;
            b_health_reg <= B_MAX;
            b_dead_reg   <= 1'b0;
            out_reg      <= '0;
        end else begin
            p_state_reg  <= p_state_next;
            p_health_reg <= p_health_next;
            iframe_reg   <= iframe_next;
            blink_reg    <= blink_next;
            phase_reg    <= phase_next;
            b_state_reg  <= b_state_next;
            b_health_reg <= b_health_next;
            b_dead_reg   <= b_dead_next;
            out_reg      <= out_next;
        end
    end

    // Player FSM: a hit and a heal in the same ALIVE cycle resolve as the hit.
    always_comb begin
        p_state_next  = p_state_reg;
        p_health_next = p_health_reg;
        iframe_next   = iframe_reg;
        blink_next    = blink_reg;
        phase_next    = phase_reg;
        if (bus.new_game) begin
            p_state_next  = ALIVE;
            p_health_next = P_MAX;
            iframe_next   = '0;
            blink_next    = '0;
            phase_next    = 1'b0;
        end else begin
            unique case (p_state_reg)
                ALIVE: begin
                    if (bus.player_hit && p_health_reg != '0) begin
                        p_health_next = p_health_reg - PW'(1);
                        if (p_health_reg == PW'(1)) begin
                            p_state_next = DEAD;
                        end else begin
                            p_state_next = INVULN;
                            iframe_next  = I_LOAD;
                            blink_next   = K_LOAD;
                            phase_next   = 1'b0;
                        end
                    end else if (bus.player_heal && p_health_reg != P_MAX) begin
                        p_health_next = p_health_reg + PW'(1);
                    end
                end
                INVULN: begin
                    if (bus.player_heal && p_health_reg != P_MAX) begin
                        p_health_next = p_health_reg + PW'(1);
                    end
                    if (bus.tick) begin
                        if (blink_reg <= KW'(1)) begin
                            blink_next = K_LOAD;
                            phase_next = ~phase_reg;
                        end else begin
                            blink_next = blink_reg - KW'(1);
                        end
                        // Leaving i-frames always restores a lit bar.
                        if (iframe_reg <= IW'(1)) begin
                            p_state_next = ALIVE;
                            iframe_next  = '0;
                            phase_next   = 1'b0;
                        end else begin
                            iframe_next = iframe_reg - IW'(1);
                        end
                    end
                end
                DEAD: begin
                end
                default: begin
                    p_state_next = ALIVE;
                end
            endcase
        end
    end

    // Boss FSM: dropping boss_active leaves FIGHT even if a hit lands that cycle.
    always_comb begin
        b_state_next  = b_state_reg;
        b_health_next = b_health_reg;
        b_dead_next   = 1'b0;
        if (bus.new_game) begin
            b_state_next  = IDLE;
            b_health_next = B_MAX;
        end else begin
            unique case (b_state_reg)
                IDLE: begin
                    if (bus.boss_active) begin
                        b_state_next  = FIGHT;
                        b_health_next = B_MAX;
                    end
                end
                FIGHT: begin
                    if (!bus.boss_active) begin
                        b_state_next = IDLE;
                    end else if (bus.boss_hit && b_health_reg != '0) begin
                        b_health_next = b_health_reg - BW'(1);
                        if (b_health_reg == BW'(1)) begin
                            b_state_next = DEFEATED;
                            b_dead_next  = 1'b1;
                        end
                    end
                end
                DEFEATED: begin
                    if (!bus.boss_active) begin
                        b_state_next = IDLE;
                    end
                end
                default: begin
                    b_state_next = IDLE;
                end
            endcase
        end
    end

    assign player_blank = (p_state_reg == INVULN) && phase_reg;
    assign boss_level   = (b_state_reg == FIGHT) ? b_health_reg : '0;

    therm_bar #(.N(PLAYER_MAX), .REVERSE(0), .W(PW)) u_player_bar (
        .value (p_health_reg),
        .bar   (player_bar)
    );

    therm_bar #(.N(BOSS_MAX), .REVERSE(1), .W(BW)) u_boss_bar (
        .value (boss_level),
        .bar   (boss_bar)
    );

    always_comb begin
        out_next = '0;
        if (!bus.new_game) begin
            out_next[PLAYER_MAX-1:0]     = player_bar & {PLAYER_MAX{~player_blank}};
            out_next[BAR_W-1 -: BOSS_MAX] = boss_bar;
        end
    end

    assign bus.player_health = p_health_reg;
    assign bus.boss_health   = b_health_reg;
    assign bus.player_dead   = (p_state_reg == DEAD);
    assign bus.boss_dead     = b_dead_reg;
    assign bus.out           = out_reg;

endmodule

// File: tb/tb_health_bar_ctrl.sv
// Vector table for health_bar_ctrl plus a hand-written asynchronous reset sequence.
// Expected records are queued as each vector is driven and compared after the edge.
module tb_health_bar_ctrl;

    typedef struct {
        logic [5:0] in;     // {tick, new_game, player_hit, player_heal, boss_active, boss_hit}
        logic [1:0] ph;
        logic [2:0] bh;
        logic       pd;
        logic       bd;
        logic [9:0] out;
    } vec_t;

    logic clk;
    logic resetn;

    int checks;
    int errors;
    vec_t vecs[50];
    vec_t sb_q[$];

    health_bar_ctrl_if #(.PLAYER_MAX(3), .BOSS_MAX(6), .BAR_W(10)) bus ();

    health_bar_ctrl #(
        .PLAYER_MAX(3), .BOSS_MAX(6), .BAR_W(10), .IFRAME_TICKS(4), .BLINK_TICKS(1)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [5:0] in, input int ph, input int bh,
                                input logic pd, input logic bd, input logic [9:0] o);
        vec_t v;
        v.in  = in;
        v.ph  = 2'(ph);
        v.bh  = 3'(bh);
        v.pd  = pd;
        v.bd  = bd;
        v.out = o;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] in);
        {bus.tick, bus.new_game, bus.player_hit, bus.player_heal,
         bus.boss_active, bus.boss_hit} = in;
    endtask

    // Drive on the falling edge, compare 1 time unit after the rising edge.
    task automatic apply_vec(input int idx, input vec_t v);
        vec_t e;
        drive(v.in);
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            $display("vec %0d in=%b ph=%0d bh=%0d pd=%b bd=%b out=%b", idx, e.in,
                     bus.player_health, bus.boss_health, bus.player_dead,
                     bus.boss_dead, bus.out);
            check($sformatf("v%0d_player_health", idx), 32'(bus.player_health), 32'(e.ph));
            check($sformatf("v%0d_boss_health", idx),   32'(bus.boss_health),   32'(e.bh));
            check($sformatf("v%0d_player_dead", idx),   32'(bus.player_dead),   32'(e.pd));
            check($sformatf("v%0d_boss_dead", idx),     32'(bus.boss_dead),     32'(e.bd));
            check($sformatf("v%0d_out", idx),           32'(bus.out),           32'(e.out));
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Boss fight, defeat and re-entry.
        vecs[0]  = mk(6'b000000, 3, 6, 0, 0, 10'b0000000111);
        vecs[1]  = mk(6'b000010, 3, 6, 0, 0, 10'b0000000111);
        vecs[2]  = mk(6'b000010, 3, 6, 0, 0, 10'b1111110111);
        vecs[3]  = mk(6'b000011, 3, 5, 0, 0, 10'b1111110111);
        vecs[4]  = mk(6'b000011, 3, 4, 0, 0, 10'b1111100111);
        vecs[5]  = mk(6'b000011, 3, 3, 0, 0, 10'b1111000111);
        vecs[6]  = mk(6'b000011, 3, 2, 0, 0, 10'b1110000111);
        vecs[7]  = mk(6'b000011, 3, 1, 0, 0, 10'b1100000111);
        vecs[8]  = mk(6'b000010, 3, 1, 0, 0, 10'b1000000111);
        vecs[9]  = mk(6'b000011, 3, 0, 0, 1, 10'b1000000111);
        vecs[10] = mk(6'b000011, 3, 0, 0, 0, 10'b0000000111);
        vecs[11] = mk(6'b000000, 3, 0, 0, 0, 10'b0000000111);
        vecs[12] = mk(6'b000010, 3, 6, 0, 0, 10'b0000000111);
        vecs[13] = mk(6'b000000, 3, 6, 0, 0, 10'b1111110111);
        vecs[14] = mk(6'b000000, 3, 6, 0, 0, 10'b0000000111);
        // I-frames with blinking; hit on the 2nd tick is ignored.
        vecs[15] = mk(6'b001000, 2, 6, 0, 0, 10'b0000000111);
        vecs[16] = mk(6'b000000, 2, 6, 0, 0, 10'b0000000011);
        vecs[17] = mk(6'b100000, 2, 6, 0, 0, 10'b0000000011);
        vecs[18] = mk(6'b000000, 2, 6, 0, 0, 10'b0000000000);
        vecs[19] = mk(6'b101000, 2, 6, 0, 0, 10'b0000000000);
        vecs[20] = mk(6'b000000, 2, 6, 0, 0, 10'b0000000011);
        vecs[21] = mk(6'b100000, 2, 6, 0, 0, 10'b0000000011);
        vecs[22] = mk(6'b000000, 2, 6, 0, 0, 10'b0000000000);
        vecs[23] = mk(6'b100000, 2, 6, 0, 0, 10'b0000000000);
        vecs[24] = mk(6'b000000, 2, 6, 0, 0, 10'b0000000011);
        // Heal, simultaneous hit+heal, heal during i-frames, saturation.
        vecs[25] = mk(6'b000100, 3, 6, 0, 0, 10'b0000000011);
        vecs[26] = mk(6'b001100, 2, 6, 0, 0, 10'b0000000111);
        vecs[27] = mk(6'b000100, 3, 6, 0, 0, 10'b0000000011);
        vecs[28] = mk(6'b101000, 3, 6, 0, 0, 10'b0000000111);
        vecs[29] = mk(6'b100000, 3, 6, 0, 0, 10'b0000000000);
        vecs[30] = mk(6'b100000, 3, 6, 0, 0, 10'b0000000111);
        vecs[31] = mk(6'b100000, 3, 6, 0, 0, 10'b0000000000);
        vecs[32] = mk(6'b000000, 3, 6, 0, 0, 10'b0000000111);
        vecs[33] = mk(6'b000100, 3, 6, 0, 0, 10'b0000000111);
        // Lethal path with hits spaced beyond the i-frame window.
        vecs[34] = mk(6'b001000, 2, 6, 0, 0, 10'b0000000111);
        vecs[35] = mk(6'b100000, 2, 6, 0, 0, 10'b0000000011);
        vecs[36] = mk(6'b100000, 2, 6, 0, 0, 10'b0000000000);
        vecs[37] = mk(6'b100000, 2, 6, 0, 0, 10'b0000000011);
        vecs[38] = mk(6'b100000, 2, 6, 0, 0, 10'b0000000000);
        vecs[39] = mk(6'b000000, 2, 6, 0, 0, 10'b0000000011);
        vecs[40] = mk(6'b001000, 1, 6, 0, 0, 10'b0000000011);
        vecs[41] = mk(6'b100000, 1, 6, 0, 0, 10'b0000000001);
        vecs[42] = mk(6'b100000, 1, 6, 0, 0, 10'b0000000000);
        vecs[43] = mk(6'b100000, 1, 6, 0, 0, 10'b0000000001);
        vecs[44] = mk(6'b100000, 1, 6, 0, 0, 10'b0000000000);
        vecs[45] = mk(6'b001000, 0, 6, 1, 0, 10'b0000000001);
        vecs[46] = mk(6'b000100, 0, 6, 1, 0, 10'b0000000000);
        vecs[47] = mk(6'b001000, 0, 6, 1, 0, 10'b0000000000);
        // new_game overrides simultaneous events.
        vecs[48] = mk(6'b011111, 3, 6, 0, 0, 10'b0000000000);
        vecs[49] = mk(6'b000000, 3, 6, 0, 0, 10'b0000000111);

        resetn = 1'b0;
        drive(6'b000000);
        repeat (2) @(negedge clk);
        check("reset_out",           32'(bus.out),           32'h0);
        check("reset_player_health", 32'(bus.player_health), 32'd3);
        check("reset_boss_health",   32'(bus.boss_health),   32'd6);
        check("reset_player_dead",   32'(bus.player_dead),   32'd0);
        check("reset_boss_dead",     32'(bus.boss_dead),     32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 50; i++) begin
            apply_vec(i, vecs[i]);
        end

        // Asynchronous reset while the player blinks and the boss is mid-fight.
        apply_vec(50, mk(6'b001010, 2, 6, 0, 0, 10'b0000000111));
        apply_vec(51, mk(6'b000010, 2, 6, 0, 0, 10'b1111110011));
        #2;
        resetn = 1'b0;
        #1;
        $display("async reset: out=%b ph=%0d bh=%0d", bus.out, bus.player_health, bus.boss_health);
        check("async_out",           32'(bus.out),           32'h0);
        check("async_player_health", 32'(bus.player_health), 32'd3);
        check("async_boss_health",   32'(bus.boss_health),   32'd6);
        @(negedge clk);
        resetn = 1'b1;
        apply_vec(52, mk(6'b000000, 3, 6, 0, 0, 10'b0000000111));
        apply_vec(53, mk(6'b000000, 3, 6, 0, 0, 10'b0000000111));

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/health_bar_ctrl.md
Name: health_bar_ctrl

Overview:
- Parametrised health tracker and LED bar driver for the player and the boss.
- Holds both health counters internally and applies hit/heal events.
- Runs a player invulnerability (i-frame) window with a blinking bar.
- Drives one registered bar vector: player thermometer in the low bits, boss bar right-aligned in the high bits.
- Sits between the game-logic FSM (event pulses) and the board LEDR outputs.

Parameters:
- PLAYER_MAX, 3, maximum player health; width of the player bar.
- BOSS_MAX, 6, maximum boss health; width of the boss bar.
- BAR_W, 10, total bar width. Must satisfy BAR_W >= PLAYER_MAX + BOSS_MAX; bits between the two bars are gap bits and are always 0.
- IFRAME_TICKS, 4, length of the invulnerability window after a non-lethal player hit, counted in game ticks.
- BLINK_TICKS, 1, game ticks per blink phase during i-frames.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- tick  in  1  game-tick enable, one clk wide; the i-frame and blink timers advance only on tick.
- new_game  in  1  synchronous reload of all state to its reset values; highest priority.
- player_hit  in  1  pulse: player takes 1 damage.
- player_heal  in  1  pulse: player regains 1 health.
- boss_active  in  1  level: boss encounter in progress.
- boss_hit  in  1  pulse: boss takes 1 damage.
- player_health  out  $clog2(PLAYER_MAX+1)  current player health.
- boss_health  out  $clog2(BOSS_MAX+1)  current boss health.
- player_dead  out  1  level: player FSM is in DEAD.
- boss_dead  out  1  one-cycle pulse on boss defeat.
- out  out  BAR_W  registered LED bar.

Behaviour:
- Reset (resetn low, asynchronous) and new_game (synchronous) both give:
  - player_health = PLAYER_MAX, boss_health = BOSS_MAX
  - player FSM = ALIVE, boss FSM = IDLE
  - timers = 0, blink phase = 0
  - out = 0, player_dead = 0, boss_dead = 0
- While new_game is high, all other inputs are ignored.
- Player FSM:
  - ALIVE:
    - hit with health > 1: decrement health, go to INVULN, load the i-frame timer with IFRAME_TICKS, blink timer with BLINK_TICKS, phase = 0.
    - hit with health = 1: health = 0, go to DEAD.
    - heal: health +1, saturating at PLAYER_MAX.
    - hit and heal in the same cycle: hit wins, heal is dropped.
  - INVULN:
    - player_hit is ignored; heal is applied, saturating.
    - On each tick: the i-frame timer decrements; when the timer is 1 on a tick, return to ALIVE with phase = 0.
    - On each tick: the blink timer decrements; at 1 it reloads and phase toggles.
  - DEAD:
    - hit and heal are ignored; player_dead = 1; exit only via new_game or reset.
- Boss FSM:
  - IDLE:
    - boss_active = 1: go to FIGHT and reload boss_health = BOSS_MAX.
  - FIGHT:
    - boss_hit decrements boss_health.
    - Hit at health 1: health = 0, go to DEFEATED, boss_dead pulses high for exactly that transition cycle.
    - boss_active = 0: go to IDLE (health is reloaded on the next entry).
  - DEFEATED:
    - Bar dark; boss_hit ignored.
    - Return to IDLE when boss_active = 0.
- Bar encoding (registered, 1-cycle latency from any health/state change):
  - out[k] = (player_health > k) & ~(INVULN & phase), for k < PLAYER_MAX.
  - out[BAR_W-1-k] = (boss FSM == FIGHT) & (boss_health > k), for k < BOSS_MAX; the boss bar fills from the MSB downward.
  - Gap bits are always 0.
- Width rules:
  - Counters never wrap: heal saturates at max, and hits are only accepted from nonzero health.
  - Health values outside 0..MAX are unreachable.
- Elaboration check: instantiation fails if BAR_W < PLAYER_MAX + BOSS_MAX, or if any parameter is 0.

Decomposition:
- Shared package game_pkg:
  - enum player_state_t {ALIVE, INVULN, DEAD}
  - enum boss_state_t {IDLE, FIGHT, DEFEATED}
  - default constants PLAYER_MAX_DEF and BOSS_MAX_DEF
- One natural sub-module: therm_bar (parameters N and REVERSE; input value, output N-bit thermometer), instantiated once for the player bar and once for the boss bar.

Test Plan:
- Reset, then release: after 1 clk, out = 10'b0000000111, player_health = 3, boss_health = 6, player_dead = 0.
- boss_active = 1 for 2 clk: out = 10'b1111110111. Then 5 boss_hit pulses: out = 10'b1000000111. Then 1 more boss_hit: boss_dead high for 1 cycle, out = 10'b0000000111, and boss_hit afterwards is ignored.
- I-frames: player_hit → health 2, out[2:0] alternates 011/000 on each tick. A player_hit on the 2nd tick is ignored. After 4 ticks, out[2:0] = 011 steady and the FSM is in ALIVE.
- Simultaneous player_hit + player_heal at health 3 in ALIVE → health 2 (hit wins). player_heal at health 3 → stays 3.
- Lethal path: three hits, each spaced more than IFRAME_TICKS apart → player_dead = 1 and out[2:0] = 000. Further heal or hit → no change. new_game → out = 10'b0000000111 after 1 clk.
- resetn asserted mid-INVULN with the boss in FIGHT → out = 0 immediately (asynchronous). After release, the player is full and the boss FSM is in IDLE.
